mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Executes load/store operators over a single-outstanding request/acknowledge data bus, with byte-lane steering, sign/zero extension and misalignment detection.
- Raises stall_request while an access is in flight, so the control unit holds stages 0-4 and inserts a bubble into MEM/WB.
- Non-memory operators pass through to writeback combinationally.

---
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a single-outstanding req/ack data bus with
// big-endian lane steering, extends load data and stalls the pipeline meanwhile.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_instruction,
  input  logic [7:0]  mem_operator,
  input  logic [31:0] mem_operand_a,
  input  logic [31:0] mem_operand_b,
  input  logic        mem_reg_write_enable,
  input  logic [4:0]  mem_reg_write_address,
  input  logic [31:0] mem_reg_write_data,
  output logic        wb_reg_write_enable,
  output logic [4:0]  wb_reg_write_address,
  output logic [31:0] wb_reg_write_data,
  output logic        stall_request,
  output logic        address_error,
  output logic        bus_error,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_select,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack
);

  localparam logic [7:0] OP_LB  = 8'h10;
  localparam logic [7:0] OP_LBU = 8'h11;
  localparam logic [7:0] OP_LH  = 8'h12;
  localparam logic [7:0] OP_LHU = 8'h13;
  localparam logic [7:0] OP_LW  = 8'h14;
  localparam logic [7:0] OP_SB  = 8'h18;
  localparam logic [7:0] OP_SH  = 8'h19;
  localparam logic [7:0] OP_SW  = 8'h1A;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t      state;
  logic [7:0]  count;
  logic [31:0] read_data;

  logic        is_load;
  logic        is_store;
  logic        is_signed;
  logic [1:0]  size;
  logic        is_mem;
  logic        misaligned;
  logic        start;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;

  // The instruction word is carried for debug visibility only.
  logic unused_debug;
  assign unused_debug = ^mem_instruction;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_WORD;
    case (mem_operator)
      OP_LB:  begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
      OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LH:  begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
      OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      OP_LW:  begin is_load  = 1'b1; size = SZ_WORD; end
      OP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:  begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  assign is_mem        = is_load | is_store;
  assign misaligned    = ((size == SZ_HALF) && mem_operand_a[0]) ||
                         ((size == SZ_WORD) && (mem_operand_a[1:0] != 2'b00));
  assign address_error = is_mem && misaligned;
  assign start         = (state == ST_IDLE) && is_mem && !misaligned;

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    sel   = 4'b1111;
    wdata = mem_operand_b;
    case (size)
      SZ_BYTE: begin
        sel   = 4'b1000 >> mem_operand_a[1:0];
        wdata = {4{mem_operand_b[7:0]}};
      end
      SZ_HALF: begin
        sel   = mem_operand_a[1] ? 4'b0011 : 4'b1100;
        wdata = {2{mem_operand_b[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = 8'h00;
    case (mem_operand_a[1:0])
      2'd0: load_byte = read_data[31:24];
      2'd1: load_byte = read_data[23:16];
      2'd2: load_byte = read_data[15:8];
      2'd3: load_byte = read_data[7:0];
      default: ;
    endcase
    load_half = mem_operand_a[1] ? read_data[15:0] : read_data[31:16];
    case (size)
      SZ_BYTE: load_value = {{24{is_signed & load_byte[7]}}, load_byte};
      SZ_HALF: load_value = {{16{is_signed & load_half[15]}}, load_half};
      default: load_value = read_data;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      count           <= '0;
      read_data       <= '0;
      bus_error       <= 1'b0;
      bus_request     <= 1'b0;
      bus_write       <= 1'b0;
      bus_address     <= '0;
      bus_byte_select <= '0;
      bus_write_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bus_request     <= 1'b1;
            bus_write       <= is_store;
            bus_address     <= {mem_operand_a[31:2], 2'b00};
            bus_byte_select <= sel;
            bus_write_data  <= is_store ? wdata : '0;
            count           <= '0;
            bus_error       <= 1'b0;
            state           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (bus_ack) begin
            read_data   <= bus_read_data;
            bus_request <= 1'b0;
            bus_write   <= 1'b0;
            bus_error   <= 1'b0;
            state       <= ST_DONE;
          end else begin
            count <= count + 8'd1;
            if (count == TIMEOUT_LAST) begin
              bus_request <= 1'b0;
              bus_write   <= 1'b0;
              bus_error   <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wb_reg_write_enable  = mem_reg_write_enable;
    wb_reg_write_address = mem_reg_write_address;
    wb_reg_write_data    = mem_reg_write_data;
    stall_request        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_mem) begin
          wb_reg_write_enable = 1'b0;
          stall_request       = !misaligned;
        end
      end
      ST_WAIT: begin
        wb_reg_write_enable = 1'b0;
        stall_request       = 1'b1;
      end
      ST_DONE: begin
        wb_reg_write_enable = is_load && !bus_error;
        if (is_load) wb_reg_write_data = load_value;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses plus
// reset-in-flight, multi-cycle ack and timeout sequences.
module tb_mem_access_unit;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'h10;
  localparam logic [7:0] OP_LBU = 8'h11;
  localparam logic [7:0] OP_LH  = 8'h12;
  localparam logic [7:0] OP_LHU = 8'h13;
  localparam logic [7:0] OP_LW  = 8'h14;
  localparam logic [7:0] OP_SB  = 8'h18;
  localparam logic [7:0] OP_SH  = 8'h19;
  localparam logic [7:0] OP_SW  = 8'h1A;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_instruction = '0;
  logic [7:0]  mem_operator = OP_NOP;
  logic [31:0] mem_operand_a = '0;
  logic [31:0] mem_operand_b = '0;
  logic        mem_reg_write_enable = 1'b0;
  logic [4:0]  mem_reg_write_address = '0;
  logic [31:0] mem_reg_write_data = '0;
  logic        wb_reg_write_enable;
  logic [4:0]  wb_reg_write_address;
  logic [31:0] wb_reg_write_data;
  logic        stall_request;
  logic        address_error;
  logic        bus_error;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data = '0;
  logic        bus_ack = 1'b0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .mem_instruction(mem_instruction), .mem_operator(mem_operator),
    .mem_operand_a(mem_operand_a), .mem_operand_b(mem_operand_b),
    .mem_reg_write_enable(mem_reg_write_enable),
    .mem_reg_write_address(mem_reg_write_address),
    .mem_reg_write_data(mem_reg_write_data),
    .wb_reg_write_enable(wb_reg_write_enable),
    .wb_reg_write_address(wb_reg_write_address),
    .wb_reg_write_data(wb_reg_write_data),
    .stall_request(stall_request), .address_error(address_error),
    .bus_error(bus_error), .bus_request(bus_request), .bus_write(bus_write),
    .bus_address(bus_address), .bus_byte_select(bus_byte_select),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
    .bus_ack(bus_ack)
  );

  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad = 0;

  // Results captured by do_access.
  int unsigned stall_cnt, req_cnt;
  logic        w_write, d_en, d_err;
  logic [31:0] w_addr, w_wdata, d_data;
  logic [3:0]  w_sel;
  logic [4:0]  d_waddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_inputs(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
    mem_operator          = op;
    mem_operand_a         = a;
    mem_operand_b         = b;
    mem_reg_write_enable  = 1'b1;
    mem_reg_write_address = rd;
    mem_reg_write_data    = 32'h5555_5555;
  endtask

  // Runs one access from IDLE; ack_at is the 1-based WAIT cycle that sees bus_ack (0 = never).
  task automatic do_access(input int unsigned ack_at, input logic [31:0] rdata);
    int unsigned wait_n = 0;
    bit finished = 0;
    stall_cnt = 0;
    req_cnt   = 0;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (!stall_request) begin
        finished = 1;
        break;
      end
      stall_cnt++;
      if (bus_request) begin
        req_cnt++;
        wait_n++;
        if (wait_n == 1) begin
          w_addr  = bus_address;
          w_sel   = bus_byte_select;
          w_wdata = bus_write_data;
          w_write = bus_write;
        end
        bus_ack       = (wait_n == ack_at);
        bus_read_data = rdata;
      end
      tick();
      bus_ack = 1'b0;
      #1;
    end
    if (!finished) begin
      bad++;
      total++;
      $display("FAIL access_timeout: stall_request still high after 20 cycles");
    end
    d_en    = wb_reg_write_enable;
    d_data  = wb_reg_write_data;
    d_err   = bus_error;
    d_waddr = wb_reg_write_address;
    tick();
    mem_operator = OP_NOP;
    #1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] b;
    logic [31:0] rdata;
    logic        aerr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        wr;
    logic        wb_en;
    logic [31:0] wb_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{OP_LB,  32'h0000_0103, 32'h0, 32'h11F0_2233, 1'b0, 4'b0001, 32'h0, 1'b0, 1'b1, 32'h0000_0033};
    vecs[1]  = '{OP_LBU, 32'h0000_0101, 32'h0, 32'h11F0_2233, 1'b0, 4'b0100, 32'h0, 1'b0, 1'b1, 32'h0000_00F0};
    vecs[2]  = '{OP_LH,  32'h0000_0200, 32'h0, 32'h8001_7FFF, 1'b0, 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001};
    vecs[3]  = '{OP_LHU, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 1'b0, 4'b0011, 32'h0, 1'b0, 1'b1, 32'h0000_7FFF};
    vecs[4]  = '{OP_LH,  32'h0000_0202, 32'h0, 32'h1234_9ABC, 1'b0, 4'b0011, 32'h0, 1'b0, 1'b1, 32'hFFFF_9ABC};
    vecs[5]  = '{OP_LW,  32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{OP_SB,  32'h0000_0402, 32'h1234_56A5, 32'h0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{OP_SH,  32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 1'b0, 4'b0011, 32'hBEEF_BEEF, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{OP_SW,  32'h0000_0500, 32'hCAFE_F00D, 32'h0, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{OP_LW,  32'h0000_0306, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{OP_SH,  32'h0000_0201, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{OP_LHU, 32'h0000_0203, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0};

    // Reset state.
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_bus_request", {31'd0, bus_request}, 32'd0);
    check("rst_bus_address", bus_address, 32'd0);
    check("rst_byte_select", {28'd0, bus_byte_select}, 32'd0);
    check("rst_write_data", bus_write_data, 32'd0);
    check("rst_stall", {31'd0, stall_request}, 32'd0);
    check("rst_bus_error", {31'd0, bus_error}, 32'd0);

    // Reset held two cycles while in WAIT.
    set_inputs(OP_LW, 32'h0000_0300, 32'h0, 5'd7);
    tick();
    check("midrst_in_wait", {31'd0, bus_request}, 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_req_dropped", {31'd0, bus_request}, 32'd0);
    tick();
    mem_operator = OP_NOP;
    reset = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall_request}, 32'd0);
    check("midrst_addr", bus_address, 32'd0);
    bus_ack = 1'b1;
    bus_read_data = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0;
    #1;
    check("stale_ack_req", {31'd0, bus_request}, 32'd0);
    check("stale_ack_stall", {31'd0, stall_request}, 32'd0);
    check("stale_ack_err", {31'd0, bus_error}, 32'd0);

    // Non-memory passthrough.
    mem_operator = OP_ADD;
    mem_operand_a = 32'h0000_0040;
    mem_reg_write_enable = 1'b1;
    mem_reg_write_address = 5'd5;
    mem_reg_write_data = 32'h0000_1234;
    #1;
    check("pass_en", {31'd0, wb_reg_write_enable}, 32'd1);
    check("pass_addr", {27'd0, wb_reg_write_address}, 32'd5);
    check("pass_data", wb_reg_write_data, 32'h0000_1234);
    check("pass_stall", {31'd0, stall_request}, 32'd0);
    tick();
    check("pass_no_req", {31'd0, bus_request}, 32'd0);

    // LB with ack on the second WAIT cycle.
    set_inputs(OP_LB, 32'h0000_0101, 32'h0, 5'd9);
    do_access(2, 32'h11F0_2233);
    check("lb2_stall_cycles", stall_cnt, 32'd3);
    check("lb2_addr", w_addr, 32'h0000_0100);
    check("lb2_sel", {28'd0, w_sel}, 32'b0100);
    check("lb2_wb_en", {31'd0, d_en}, 32'd1);
    check("lb2_wb_data", d_data, 32'hFFFF_FFF0);
    check("lb2_wb_addr", {27'd0, d_waddr}, 32'd9);
    set_inputs(OP_LBU, 32'h0000_0101, 32'h0, 5'd10);
    do_access(2, 32'h11F0_2233);
    check("lbu2_wb_data", d_data, 32'h0000_00F0);

    // Vector table, ack in the first WAIT cycle.
    for (int i = 0; i < 12; i++) begin
      set_inputs(vecs[i].op, vecs[i].addr, vecs[i].b, 5'(i + 1));
      #1;
      check($sformatf("v%0d_aerr", i), {31'd0, address_error}, {31'd0, vecs[i].aerr});
      if (vecs[i].aerr) begin
        check($sformatf("v%0d_stall", i), {31'd0, stall_request}, 32'd0);
        check($sformatf("v%0d_wb_en", i), {31'd0, wb_reg_write_enable}, 32'd0);
        tick();
        #1;
        check($sformatf("v%0d_no_req", i), {31'd0, bus_request}, 32'd0);
        mem_operator = OP_NOP;
        tick();
      end else begin
        do_access(1, vecs[i].rdata);
        check($sformatf("v%0d_stall_cycles", i), stall_cnt, 32'd2);
        check($sformatf("v%0d_addr", i), w_addr, vecs[i].addr & 32'hFFFF_FFFC);
        check($sformatf("v%0d_sel", i), {28'd0, w_sel}, {28'd0, vecs[i].sel});
        check($sformatf("v%0d_wdata", i), w_wdata, vecs[i].wdata);
        check($sformatf("v%0d_write", i), {31'd0, w_write}, {31'd0, vecs[i].wr});
        check($sformatf("v%0d_wb_en", i), {31'd0, d_en}, {31'd0, vecs[i].wb_en});
        check($sformatf("v%0d_bus_err", i), {31'd0, d_err}, 32'd0);
        if (vecs[i].wb_en)
          check($sformatf("v%0d_wb_data", i), d_data, vecs[i].wb_data);
      end
    end

    // Timeout with no ack (TIMEOUT_CYCLES=4).
    set_inputs(OP_LW, 32'h0000_0300, 32'h0, 5'd3);
    do_access(0, 32'h0);
    check("to_req_cycles", req_cnt, 32'd4);
    check("to_bus_error", {31'd0, d_err}, 32'd1);
    check("to_wb_en", {31'd0, d_en}, 32'd0);
    check("to_idle_req", {31'd0, bus_request}, 32'd0);
    check("to_idle_stall", {31'd0, stall_request}, 32'd0);

    // Ack on the last permitted cycle beats the timeout.
    set_inputs(OP_LW, 32'h0000_0300, 32'h0, 5'd4);
    do_access(4, 32'h0BAD_F00D);
    check("late_req_cycles", req_cnt, 32'd4);
    check("late_bus_error", {31'd0, d_err}, 32'd0);
    check("late_wb_en", {31'd0, d_en}, 32'd1);
    check("late_wb_data", d_data, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
